// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction controller: opcode constants and FSM state encoding.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_AND = 2'b10;
    localparam logic [1:0] ALUOP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, two asynchronous operand read ports and one
// asynchronous debug read port. Every entry clears on reset.
module alu_regfile #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem_q [2**AW];

    // NOTE: this array is reset because every register must read 0 straight after reset;
    // that forces flops rather than a RAM macro, which is fine at this size. State is
    // assigned with <= so that all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd1      = mem_q[ra1];
    assign rd2      = mem_q[ra2];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Instruction controller driving a downstream registered ALU (IDLE -> EXEC -> WB, LI skips EXEC).
// Optional zero/negative flags are compiled in when ALU_CTRL_FLAGS_EN is defined.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_li,
    input  logic [1:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          z_flag,
    output logic          n_flag
);

    state_e        state_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q;
    logic          li_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic [1:0]    alu_op_q;
    logic          done_q;

    logic          accept;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign rf_we    = (state_q == ST_WB);
    assign rf_wdata = li_q ? imm_q : alu_result;

    alu_regfile #(
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (rf_wdata),
        .ra1      (in_rs1),
        .rd1      (rf_rd1),
        .ra2      (in_rs2),
        .rd2      (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Operands are captured at the accept edge so they are stable for the whole EXEC cycle
    // and the ALU registers its result at the EXEC->WB edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_q     <= '0;
            imm_q    <= '0;
            li_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALUOP_ADD;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        rd_q  <= in_rd;
                        imm_q <= in_imm;
                        li_q  <= in_li;
                        if (in_li) begin
                            state_q <= ST_WB;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_EXEC;
                            alu_a_q  <= rf_rd1;
                            alu_b_q  <= rf_rd2;
                            alu_op_q <= in_op;
                        end
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_WB;
                    done_q  <= 1'b1;
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign done   = done_q;

`ifdef ALU_CTRL_FLAGS_EN
    logic z_q;
    logic n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (state_q == ST_WB && !li_q) begin
            z_q <= (alu_result == '0);
            n_q <= alu_result[DW-1];
        end
    end

    assign z_flag = z_q;
    assign n_flag = n_q;
`else
    assign z_flag = 1'b0;
    assign n_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a registered ALU model on alu_result.
`timescale 1ns/1ps
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_li;
    logic [1:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [3:0] in_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result = '0;
    logic       done;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic       z_flag;
    logic       n_flag;

    int checks = 0;
    int errors = 0;

    alu_ctrl #(.DW(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_li      (in_li),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .z_flag     (z_flag),
        .n_flag     (n_flag)
    );

    always #5 clk = ~clk;

    // Downstream registered ALU: result valid one edge after operands are presented.
    always @(posedge clk) begin
        case (alu_op)
            ALUOP_ADD: alu_result <= alu_a + alu_b;
            ALUOP_SUB: alu_result <= alu_a - alu_b;
            ALUOP_AND: alu_result <= alu_a & alu_b;
            default:   alu_result <= alu_a | alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic dbg_check(input string tag, input logic [1:0] addr, input logic [3:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, {28'd0, dbg_data}, {28'd0, exp});
    endtask

    // Issues one instruction from IDLE, measures accept-to-done latency and returns at
    // #1 after the WB->IDLE edge, when the write is visible.
    task automatic run_instr(input string tag, input logic li, input logic [1:0] op,
                             input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [3:0] imm,
                             input int exp_lat);
        int lat;
        @(negedge clk);
        in_li    = li;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_valid = 1'b1;
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_ready;
        int n_done;
        logic exp_z;
        logic exp_n;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_li    = 1'b0;
        in_op    = 2'b00;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        in_imm   = '0;
        dbg_addr = '0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_alu_a", {28'd0, alu_a}, 32'd0);
        check("rst_alu_b", {28'd0, alu_b}, 32'd0);
        check("rst_alu_op", {30'd0, alu_op}, 32'd0);
        check("rst_flags", {30'd0, z_flag, n_flag}, 32'd0);
        for (int i = 0; i < 4; i++) dbg_check("rst_reg", i[1:0], 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        run_instr("li_r0", 1'b1, 2'b00, 2'd0, 2'd0, 2'd0, 4'd4, 1);
        dbg_check("r0_4", 2'd0, 4'd4);
        run_instr("li_r1", 1'b1, 2'b00, 2'd1, 2'd0, 2'd0, 4'd6, 1);
        dbg_check("r1_6", 2'd1, 4'd6);
        check("li_flags", {30'd0, z_flag, n_flag}, 32'd0);

        run_instr("add", 1'b0, ALUOP_ADD, 2'd2, 2'd0, 2'd1, 4'd0, 2);
        dbg_check("add_r2", 2'd2, 4'b1010);
        check("add_alu_a_hold", {28'd0, alu_a}, 32'd4);
        check("add_alu_b_hold", {28'd0, alu_b}, 32'd6);
        check("add_alu_op_hold", {30'd0, alu_op}, {30'd0, ALUOP_ADD});
`ifdef ALU_CTRL_FLAGS_EN
        exp_z = 1'b0;
        exp_n = 1'b1;
`else
        exp_z = 1'b0;
        exp_n = 1'b0;
`endif
        check("add_z", {31'd0, z_flag}, {31'd0, exp_z});
        check("add_n", {31'd0, n_flag}, {31'd0, exp_n});

        run_instr("sub", 1'b0, ALUOP_SUB, 2'd3, 2'd0, 2'd1, 4'd0, 2);
        dbg_check("sub_r3", 2'd3, 4'b1110);
        run_instr("and", 1'b0, ALUOP_AND, 2'd2, 2'd0, 2'd1, 4'd0, 2);
        dbg_check("and_r2", 2'd2, 4'b0100);
        run_instr("or", 1'b0, ALUOP_OR, 2'd2, 2'd0, 2'd1, 4'd0, 2);
        dbg_check("or_r2", 2'd2, 4'b0110);

        // Back-to-back r3 = r3 + r1 with in_valid held: 14 -> 4 -> 10 -> 0 if each is taken once.
        @(negedge clk);
        in_li    = 1'b0;
        in_op    = ALUOP_ADD;
        in_rd    = 2'd3;
        in_rs1   = 2'd3;
        in_rs2   = 2'd1;
        in_valid = 1'b1;
        n_ready  = 0;
        n_done   = 0;
        for (int i = 0; i < 9; i++) begin
            if (in_ready) n_ready++;
            if (done) n_done++;
            if (done && in_ready) n_ready += 100;
            if (i == 8) in_valid = 1'b0;
            @(negedge clk);
        end
        check("stream_ready_cycles", n_ready, 3);
        check("stream_done_pulses", n_done, 3);
        dbg_check("stream_r3", 2'd3, 4'd0);

        run_instr("sub_self", 1'b0, ALUOP_SUB, 2'd0, 2'd0, 2'd0, 4'd0, 2);
        dbg_check("sub_self_r0", 2'd0, 4'd0);
`ifdef ALU_CTRL_FLAGS_EN
        exp_z = 1'b1;
`else
        exp_z = 1'b0;
`endif
        check("sub_self_z", {31'd0, z_flag}, {31'd0, exp_z});
        check("sub_self_n", {31'd0, n_flag}, 32'd0);

        // Reset during EXEC of ADD r2 = r1 + r1.
        @(negedge clk);
        in_li    = 1'b0;
        in_op    = ALUOP_ADD;
        in_rd    = 2'd2;
        in_rs1   = 2'd1;
        in_rs2   = 2'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("exec_not_ready", {31'd0, in_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("abort_alu_a", {28'd0, alu_a}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", n_done, 0);
        check("abort_ready_after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) dbg_check("abort_reg", i[1:0], 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
